// File: rtl/serial_subtractor.sv
// Bit-serial subtractor: diff = a - b - bin, LSB first, one bit per clock.
// A single full-subtractor cell is reused every cycle; the borrow is carried in a flop.
module serial_subtractor #(
   parameter int unsigned WIDTH = 8
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             start,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic             bin,
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] diff,
   output logic             borrow,
   output logic             overflow
);

   localparam int unsigned CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
   localparam logic [CW-1:0] CntLast = CW'(WIDTH - 1);

   typedef enum logic [1:0] {StIdle, StRun, StDone} state_e;

   state_e           state_q, state_d;
   logic [WIDTH-1:0] a_sh_q, a_sh_d;
   logic [WIDTH-1:0] b_sh_q, b_sh_d;
   logic [WIDTH-1:0] diff_q, diff_d;
   logic [CW-1:0]    cnt_q, cnt_d;
   logic             brw_q, brw_d;
   logic             a_msb_q, a_msb_d;
   logic             b_msb_q, b_msb_d;
   logic             borrow_q, borrow_d;
   logic             ovf_q, ovf_d;
   logic             done_q, done_d;

   // Full-subtractor cell fed from the low bits of the operand shifters.
   logic cell_x, cell_y, cell_d, cell_bout;
   assign cell_x    = a_sh_q[0];
   assign cell_y    = b_sh_q[0];
   assign cell_d    = cell_x ^ cell_y ^ brw_q;
   assign cell_bout = (~cell_x & cell_y) | (~(cell_x ^ cell_y) & brw_q);

   // Next-state and datapath update; every register holds unless written below.
   always_comb begin
      state_d  = state_q;
      a_sh_d   = a_sh_q;
      b_sh_d   = b_sh_q;
      diff_d   = diff_q;
      cnt_d    = cnt_q;
      brw_d    = brw_q;
      a_msb_d  = a_msb_q;
      b_msb_d  = b_msb_q;
      borrow_d = borrow_q;
      ovf_d    = ovf_q;
      done_d   = 1'b0;
      unique case (state_q)
         StIdle, StDone: begin
            if (start) begin
               // Fresh load; results from the previous operation are cleared here.
               state_d  = StRun;
               a_sh_d   = a;
               b_sh_d   = b;
               brw_d    = bin;
               cnt_d    = '0;
               diff_d   = '0;
               borrow_d = 1'b0;
               ovf_d    = 1'b0;
               a_msb_d  = a[WIDTH-1];
               b_msb_d  = b[WIDTH-1];
            end else begin
               state_d = StIdle;
            end
         end
         StRun: begin
            diff_d = {cell_d, diff_q[WIDTH-1:1]};
            brw_d  = cell_bout;
            a_sh_d = a_sh_q >> 1;
            b_sh_d = b_sh_q >> 1;
            if (cnt_q == CntLast) begin
               // This edge consumes the MSB: publish borrow and signed overflow.
               state_d  = StDone;
               done_d   = 1'b1;
               borrow_d = cell_bout;
               ovf_d    = (a_msb_q != b_msb_q) && (cell_d != a_msb_q);
            end else begin
               cnt_d = cnt_q + 1'b1;
            end
         end
         default: state_d = StIdle;
      endcase
   end

   // State and datapath registers with asynchronous active-low clear.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q  <= StIdle;
         a_sh_q   <= '0;
         b_sh_q   <= '0;
         diff_q   <= '0;
         cnt_q    <= '0;
         brw_q    <= 1'b0;
         a_msb_q  <= 1'b0;
         b_msb_q  <= 1'b0;
         borrow_q <= 1'b0;
         ovf_q    <= 1'b0;
         done_q   <= 1'b0;
      end else begin
         state_q  <= state_d;
         a_sh_q   <= a_sh_d;
         b_sh_q   <= b_sh_d;
         diff_q   <= diff_d;
         cnt_q    <= cnt_d;
         brw_q    <= brw_d;
         a_msb_q  <= a_msb_d;
         b_msb_q  <= b_msb_d;
         borrow_q <= borrow_d;
         ovf_q    <= ovf_d;
         done_q   <= done_d;
      end
   end

   assign busy     = (state_q == StRun);
   assign done     = done_q;
   assign diff     = diff_q;
   assign borrow   = borrow_q;
   assign overflow = ovf_q;

endmodule

// File: tb/tb_serial_subtractor.sv
// Directed bench for serial_subtractor at WIDTH=8 and WIDTH=16.
module tb_serial_subtractor;

   logic clk = 1'b0;
   logic rst_n = 1'b0;

   logic        start8 = 1'b0, bin8 = 1'b0;
   logic [7:0]  a8 = '0, b8 = '0;
   logic        busy8, done8, borrow8, ovf8;
   logic [7:0]  diff8;

   logic        start16 = 1'b0, bin16 = 1'b0;
   logic [15:0] a16 = '0, b16 = '0;
   logic        busy16, done16, borrow16, ovf16;
   logic [15:0] diff16;

   int n_cmp = 0;
   int n_bad = 0;
   int n_done8 = 0;

   always #5 clk = ~clk;

   serial_subtractor #(.WIDTH(8)) u_dut8 (
      .clk      (clk),
      .rst_n    (rst_n),
      .start    (start8),
      .a        (a8),
      .b        (b8),
      .bin      (bin8),
      .busy     (busy8),
      .done     (done8),
      .diff     (diff8),
      .borrow   (borrow8),
      .overflow (ovf8)
   );

   serial_subtractor #(.WIDTH(16)) u_dut16 (
      .clk      (clk),
      .rst_n    (rst_n),
      .start    (start16),
      .a        (a16),
      .b        (b16),
      .bin      (bin16),
      .busy     (busy16),
      .done     (done16),
      .diff     (diff16),
      .borrow   (borrow16),
      .overflow (ovf16)
   );

   // Count done pulses of the 8-bit instance (each pulse lasts exactly one cycle).
   always @(posedge clk) if (done8) n_done8++;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      if (obs !== exp) begin
         n_bad++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
      end
   endtask

   task automatic idle(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   // Wait (bounded) for done8, starting from a given latency count.
   task automatic wait_done8(input int lat0, output int lat);
      lat = lat0;
      while (!done8 && lat < 40) begin
         @(posedge clk);
         #1;
         lat++;
      end
   endtask

   task automatic run8(input string tag, input logic [7:0] a, input logic [7:0] b,
                       input logic bi, input logic [7:0] ed, input logic eb, input logic eo);
      int lat;
      a8 = a; b8 = b; bin8 = bi; start8 = 1'b1;
      @(posedge clk);
      #1;
      start8 = 1'b0;
      a8 = ~a; b8 = ~b; bin8 = ~bi;
      check({tag, ".busy"}, 32'(busy8), 32'd1);
      wait_done8(0, lat);
      check({tag, ".lat"}, 32'(lat), 32'd8);
      check({tag, ".done"}, 32'(done8), 32'd1);
      check({tag, ".diff"}, 32'(diff8), 32'(ed));
      check({tag, ".borrow"}, 32'(borrow8), 32'(eb));
      check({tag, ".ovf"}, 32'(ovf8), 32'(eo));
   endtask

   task automatic run16(input string tag, input logic [15:0] a, input logic [15:0] b,
                        input logic bi, input logic [15:0] ed, input logic eb, input logic eo);
      int lat;
      a16 = a; b16 = b; bin16 = bi; start16 = 1'b1;
      @(posedge clk);
      #1;
      start16 = 1'b0;
      lat = 0;
      while (!done16 && lat < 40) begin
         @(posedge clk);
         #1;
         lat++;
      end
      check({tag, ".lat"}, 32'(lat), 32'd16);
      check({tag, ".diff"}, 32'(diff16), 32'(ed));
      check({tag, ".borrow"}, 32'(borrow16), 32'(eb));
      check({tag, ".ovf"}, 32'(ovf16), 32'(eo));
   endtask

   initial begin
      int lat;
      int d0;
      logic [8:0]  m8;
      logic [16:0] m16;
      logic [7:0]  ra8, rb8;
      logic [15:0] ra16, rb16;
      logic        rbi;

      #12;
      check("rst.busy", 32'(busy8), 32'd0);
      check("rst.done", 32'(done8), 32'd0);
      check("rst.diff", 32'(diff8), 32'd0);
      check("rst.borrow", 32'(borrow8), 32'd0);
      check("rst.ovf", 32'(ovf8), 32'd0);
      rst_n = 1'b1;
      idle(2);

      run8("t1", 8'h05, 8'h03, 1'b0, 8'h02, 1'b0, 1'b0);
      @(posedge clk);
      #1;
      check("t1.done_fall", 32'(done8), 32'd0);
      check("t1.hold_diff", 32'(diff8), 32'h02);
      idle(2);
      run8("t2", 8'h03, 8'h05, 1'b0, 8'hFE, 1'b1, 1'b0);
      idle(1);
      run8("t3a", 8'h80, 8'h01, 1'b0, 8'h7F, 1'b0, 1'b1);
      idle(1);
      run8("t3b", 8'h7F, 8'hFF, 1'b0, 8'h80, 1'b1, 1'b1);
      idle(1);
      run8("t4", 8'h00, 8'h00, 1'b1, 8'hFF, 1'b1, 1'b0);
      idle(3);

      // start held high through most of RUN while operands churn
      d0 = n_done8;
      a8 = 8'h55; b8 = 8'h11; bin8 = 1'b0; start8 = 1'b1;
      @(posedge clk);
      #1;
      repeat (4) begin
         a8 = 8'(($urandom)); b8 = 8'(($urandom)); bin8 = 1'(($urandom));
         @(posedge clk);
         #1;
      end
      start8 = 1'b0;
      wait_done8(4, lat);
      check("hold.lat", 32'(lat), 32'd8);
      check("hold.diff", 32'(diff8), 32'h44);
      check("hold.borrow", 32'(borrow8), 32'd0);
      idle(12);
      check("hold.one_pulse", 32'(n_done8 - d0), 32'd1);

      // back-to-back: second start lands in the DONE cycle
      run8("b2b1", 8'h09, 8'h02, 1'b0, 8'h07, 1'b0, 1'b0);
      run8("b2b2", 8'h10, 8'h01, 1'b0, 8'h0F, 1'b0, 1'b0);
      idle(2);

      // asynchronous reset in the middle of a run
      d0 = n_done8;
      a8 = 8'h00; b8 = 8'h01; bin8 = 1'b0; start8 = 1'b1;
      @(posedge clk);
      #1;
      start8 = 1'b0;
      repeat (4) @(posedge clk);
      #3;
      rst_n = 1'b0;
      #1;
      check("arst.busy", 32'(busy8), 32'd0);
      check("arst.done", 32'(done8), 32'd0);
      check("arst.diff", 32'(diff8), 32'd0);
      check("arst.borrow", 32'(borrow8), 32'd0);
      check("arst.ovf", 32'(ovf8), 32'd0);
      @(negedge clk);
      rst_n = 1'b1;
      idle(12);
      check("arst.no_done", 32'(n_done8 - d0), 32'd0);
      run8("post", 8'h20, 8'h05, 1'b1, 8'h1A, 1'b0, 1'b0);
      idle(1);

      run16("w16a", 16'h1234, 16'h0235, 1'b0, 16'h0FFF, 1'b0, 1'b0);
      idle(1);
      run16("w16b", 16'h8000, 16'h0001, 1'b0, 16'h7FFF, 1'b0, 1'b1);
      idle(1);
      run16("w16c", 16'h0000, 16'hFFFF, 1'b1, 16'h0000, 1'b1, 1'b0);
      idle(1);

      // random sweep against an arithmetic reference
      for (int i = 0; i < 40; i++) begin
         ra8 = 8'($urandom); rb8 = 8'($urandom); rbi = 1'($urandom);
         m8 = {1'b0, ra8} - {1'b0, rb8} - 9'(rbi);
         run8("rnd8", ra8, rb8, rbi, m8[7:0], m8[8],
              (ra8[7] != rb8[7]) && (m8[7] != ra8[7]));
      end
      for (int i = 0; i < 20; i++) begin
         ra16 = 16'($urandom); rb16 = 16'($urandom); rbi = 1'($urandom);
         m16 = {1'b0, ra16} - {1'b0, rb16} - 17'(rbi);
         run16("rnd16", ra16, rb16, rbi, m16[15:0], m16[16],
               (ra16[15] != rb16[15]) && (m16[15] != ra16[15]));
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
